// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//
// Write-back end of the pipeline. Results from the memory stage are captured in
// the MEM/WB latch. One cycle later they are committed into the general-purpose
// register file. Two independent combinational read ports feed the decode
// stage. Register 0 always reads as zero and is never written.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : a read whose address matches a valid, non-zero latched
//               destination returns the latched data. The read sees the value
//               one cycle before it is committed.
//   undefined : reads return the register array contents only.
//
// Ports:
//   clk, rst               clock (rising edge); asynchronous active-high reset
//   mem_wd/mem_wreg/mem_wdata  destination, write-enable and data from memory stage
//   stall                  hold the MEM/WB latch contents
//   flush                  load a bubble into the MEM/WB latch (wins over stall)
//   wb_wd/wb_wreg/wb_wdata MEM/WB latch contents
//   re1/raddr1/rdata1      read port 1 (enable, address, data)
//   re2/raddr2/rdata2      read port 2 (enable, address, data)
// -----------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              stall,
    input  logic              flush,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NREGS];

    // MEM/WB latch: flush beats stall, stall beats load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_wd    <= '0;
            wb_wreg  <= 1'b0;
            wb_wdata <= '0;
        end else if (flush) begin
            wb_wd    <= '0;
            wb_wreg  <= 1'b0;
            wb_wdata <= '0;
        end else if (!stall) begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
        end
    end

    // Commit uses the latch contents from before the edge. Therefore a flush
    // does not cancel the entry being committed. While the pipeline is stalled,
    // the same entry is rewritten every cycle. This is harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_wreg && (wb_wd != '0)) begin
            regs[wb_wd] <= wb_wdata;
        end
    end

    // Read port priority: disabled or in reset, then register 0, then optional
    // bypass from the latch, then the array.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              en,
        input logic [ADDR_W-1:0] addr
    );
        logic [DATA_W-1:0] val;
        if (rst || !en || (addr == '0)) begin
            val = '0;
        end
`ifdef WB_BYPASS_EN
        else if (wb_wreg && (wb_wd != '0) && (addr == wb_wd)) begin
            val = wb_wdata;
        end
`endif
        else begin
            val = regs[addr];
        end
        return val;
    endfunction

    always_comb begin
        rdata1 = read_port(re1, raddr1);
    end

    always_comb begin
        rdata2 = read_port(re2, raddr2);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//
// Self-checking bench for wb_regfile. A behavioural model holds the register
// array and the MEM/WB latch as plain variables. The model is advanced at every
// rising edge from the stimulus the bench drives. Directed scenarios cover
// reset, basic write latency, register 0, stall/flush, dual read and
// back-to-back writes. A randomized phase then follows. The expectations for
// bypass-dependent read timing follow WB_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] mem_wd    = '0;
    logic              mem_wreg  = 1'b0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic              stall     = 1'b0;
    logic              flush     = 1'b0;
    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
    logic              re1 = 1'b0, re2 = 1'b0;
    logic [ADDR_W-1:0] raddr1 = '0, raddr2 = '0;
    logic [DATA_W-1:0] rdata1, rdata2;

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .stall(stall), .flush(flush),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_rf [NREGS];
    logic [ADDR_W-1:0] m_wd;
    logic              m_wreg;
    logic [DATA_W-1:0] m_wdata;

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
        m_wd = '0; m_wreg = 1'b0; m_wdata = '0;
    endtask

    function automatic logic [DATA_W-1:0] exp_rd(input logic en, input logic [ADDR_W-1:0] a);
        if (rst || !en || a == 0) return '0;
`ifdef WB_BYPASS_EN
        if (m_wreg && m_wd != 0 && a == m_wd) return m_wdata;
`endif
        return m_rf[a];
    endfunction

    // ---------------- driver ----------------
    // Advance one rising edge. The model first commits the entry it latched
    // before the edge, and then updates the latch. Outputs settle 1 ns later.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            if (m_wreg && m_wd != 0) m_rf[m_wd] = m_wdata;
            if (flush) begin
                m_wd = '0; m_wreg = 1'b0; m_wdata = '0;
            end else if (!stall) begin
                m_wd = mem_wd; m_wreg = mem_wreg; m_wdata = mem_wdata;
            end
        end
        #1;
    endtask

    task automatic drive_mem(input logic [ADDR_W-1:0] a, input logic we, input logic [DATA_W-1:0] d);
        mem_wd = a; mem_wreg = we; mem_wdata = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_clear();
        #1;
        n_checks++;
        if ({wb_wd, wb_wreg, wb_wdata} !== '0) $display("FAIL reset_latch: got %h/%b/%h want 0", wb_wd, wb_wreg, wb_wdata);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        // Preload r5 and confirm it is stored.
        drive_mem(5, 1'b1, 32'h1234); step();
        drive_mem(0, 1'b0, 0); step();
        re1 = 1'b1; raddr1 = 5; #1;
        n_checks++;
        if (rdata1 !== 32'h1234 || rdata1 !== exp_rd(1'b1, 5)) $display("FAIL reset_preload: got %h want 00001234", rdata1);
        else n_pass++;
        // Place a write to r9 in the latch, then assert reset between edges.
        drive_mem(9, 1'b1, 32'h77); step();
        #2; rst = 1'b1; model_clear(); #1;
        re2 = 1'b1; raddr2 = 9; #1;
        n_checks++;
        if (wb_wreg !== 1'b0 || rdata1 !== '0) $display("FAIL reset_async: wb_wreg=%b rdata1=%h want 0/0", wb_wreg, rdata1);
        else n_pass++;
        step();
        n_checks++;
        if (rdata1 !== '0 || rdata2 !== '0) $display("FAIL reset_held_read: got %h/%h want 0/0", rdata1, rdata2);
        else n_pass++;
        drive_mem(0, 1'b0, 0);
        #2; rst = 1'b0; #1;
        n_checks++;
        if (rdata1 !== '0 || rdata2 !== '0 || rdata2 !== exp_rd(1'b1, 9)) $display("FAIL reset_cleared: r5=%h r9=%h want 0/0", rdata1, rdata2);
        else n_pass++;
        step();
        n_checks++;
        if (rdata2 !== '0) $display("FAIL reset_discard: r9=%h want 0", rdata2);
        else n_pass++;
    endtask

    task automatic test_basic_write();
        logic [DATA_W-1:0] exp_t1;
`ifdef WB_BYPASS_EN
        exp_t1 = 32'hDEADBEEF;
`else
        exp_t1 = 32'h0;
`endif
        re1 = 1'b1; raddr1 = 3;
        drive_mem(3, 1'b1, 32'hDEADBEEF); step();
        drive_mem(0, 1'b0, 0);
        n_checks++;
        if ({wb_wd, wb_wreg, wb_wdata} !== {5'd3, 1'b1, 32'hDEADBEEF}) $display("FAIL basic_latch: got %h/%b/%h want 03/1/deadbeef", wb_wd, wb_wreg, wb_wdata);
        else n_pass++;
        n_checks++;
        if (rdata1 !== exp_t1) $display("FAIL basic_read_t1: got %h want %h", rdata1, exp_t1);
        else n_pass++;
        step();
        n_checks++;
        if (rdata1 !== 32'hDEADBEEF) $display("FAIL basic_read_t2: got %h want deadbeef", rdata1);
        else n_pass++;
    endtask

    task automatic test_r0_protect();
        re1 = 1'b1; raddr1 = 0; re2 = 1'b1; raddr2 = 0;
        drive_mem(0, 1'b1, 32'hFFFFFFFF);
        for (int k = 0; k < 2; k++) begin
            step();
            drive_mem(0, 1'b0, 0);
            n_checks++;
            if (rdata1 !== '0 || rdata2 !== '0) $display("FAIL r0_protect_%0d: got %h/%h want 0/0", k, rdata1, rdata2);
            else n_pass++;
        end
    endtask

    task automatic test_stall_flush();
        re1 = 1'b1; raddr1 = 7; re2 = 1'b1; raddr2 = 8;
        drive_mem(7, 1'b1, 32'h55); step();
        stall = 1'b1; drive_mem(8, 1'b1, 32'h66);
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (wb_wd !== 5'd7 || wb_wdata !== 32'h55 || rdata2 !== '0 || rdata1 !== 32'h55)
                $display("FAIL stall_hold_%0d: wd=%h data=%h r7=%h r8=%h want 07/55/55/0", k, wb_wd, wb_wdata, rdata1, rdata2);
            else n_pass++;
        end
        flush = 1'b1; step();
        flush = 1'b0; stall = 1'b0; drive_mem(0, 1'b0, 0);
        n_checks++;
        if ({wb_wd, wb_wreg, wb_wdata} !== '0 || rdata1 !== 32'h55) $display("FAIL flush_bubble: latch=%h/%b/%h r7=%h want 0/0/0/55", wb_wd, wb_wreg, wb_wdata, rdata1);
        else n_pass++;
        step();
        n_checks++;
        if (rdata2 !== '0 || rdata1 !== 32'h55) $display("FAIL flush_no_r8: r7=%h r8=%h want 55/0", rdata1, rdata2);
        else n_pass++;
    endtask

    task automatic test_dual_read();
        drive_mem(1, 1'b1, 32'hA); step();
        drive_mem(2, 1'b1, 32'hB); step();
        drive_mem(0, 1'b0, 0); step();
        re1 = 1'b1; raddr1 = 1; re2 = 1'b1; raddr2 = 2; #1;
        n_checks++;
        if (rdata1 !== 32'hA || rdata2 !== 32'hB) $display("FAIL dual_read: got %h/%h want a/b", rdata1, rdata2);
        else n_pass++;
        raddr2 = 1; #1;
        n_checks++;
        if (rdata1 !== rdata2 || rdata2 !== 32'hA) $display("FAIL dual_same_addr: got %h/%h want a/a", rdata1, rdata2);
        else n_pass++;
        re2 = 1'b0; #1;
        n_checks++;
        if (rdata2 !== '0 || rdata1 !== 32'hA) $display("FAIL re2_gate: rdata2=%h rdata1=%h want 0/a", rdata2, rdata1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] e1, e2;
`ifdef WB_BYPASS_EN
        e1 = 32'h1; e2 = 32'h2;
`else
        e1 = 32'h0; e2 = 32'h1;
`endif
        re1 = 1'b1; raddr1 = 4;
        drive_mem(4, 1'b1, 32'h1); step();
        n_checks++;
        if (rdata1 !== e1) $display("FAIL b2b_t1: got %h want %h", rdata1, e1);
        else n_pass++;
        drive_mem(4, 1'b1, 32'h2); step();
        drive_mem(0, 1'b0, 0);
        n_checks++;
        if (rdata1 !== e2) $display("FAIL b2b_t2: got %h want %h", rdata1, e2);
        else n_pass++;
        step();
        n_checks++;
        if (rdata1 !== 32'h2) $display("FAIL b2b_t3: got %h want 2", rdata1);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int k = 0; k < 400; k++) begin
            drive_mem(ADDR_W'($urandom_range(0, NREGS - 1)), 1'($urandom_range(0, 3) != 0), $urandom());
            stall  = ($urandom_range(0, 4) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            re1    = ($urandom_range(0, 3) != 0);
            re2    = ($urandom_range(0, 3) != 0);
            raddr1 = ADDR_W'($urandom_range(0, NREGS - 1));
            raddr2 = ($urandom_range(0, 2) == 0) ? m_wd : ADDR_W'($urandom_range(0, NREGS - 1));
            step();
            n_checks++;
            if ({wb_wd, wb_wreg, wb_wdata} !== {m_wd, m_wreg, m_wdata} ||
                rdata1 !== exp_rd(re1, raddr1) || rdata2 !== exp_rd(re2, raddr2)) begin
                if (errs < 10)
                    $display("FAIL random_%0d: latch=%h/%b/%h rd=%h/%h want %h/%b/%h rd=%h/%h", k,
                             wb_wd, wb_wreg, wb_wdata, rdata1, rdata2,
                             m_wd, m_wreg, m_wdata, exp_rd(re1, raddr1), exp_rd(re2, raddr2));
                errs++;
            end else n_pass++;
        end
        stall = 1'b0; flush = 1'b0; drive_mem(0, 1'b0, 0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_write();
        test_r0_protect();
        test_stall_flush();
        test_dual_read();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
